trace_cmd_receiver: RTL and testbench
=====================================

Name: trace_cmd_receiver

Overview:
Receiving end of the trace command stream. It accepts {command, address} pairs over a valid/ready handshake and buffers them in a small FIFO. At dequeue it decodes each pair into a cache operation with the address split into tag, index and offset. It presents the operation to the cache controller over a second valid/ready handshake, sequences clear/print housekeeping commands, and keeps per-class command statistics.

Parameters:
ADDR_W, 32, trace address width; must equal TAG_BITS+INDEX_BITS+OFFSET_BITS from mypkg.
FIFO_DEPTH, 4, input buffer entries; power of two, minimum 2.
CNT_W, 32, statistics counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  producer has a command.
in_ready  out  1  receiver can accept; equals !fifo_full.
in_cmd  in  4  trace command code.
in_addr  in  ADDR_W  trace address.
out_valid  out  1  decoded operation available.
out_ready  in  1  cache controller accepts operation.
out_op  out  3  op_e: OP_RD, OP_WR, OP_IF, OP_SNP_RD, OP_SNP_WR, OP_SNP_RWIM, OP_SNP_INV.
out_tag  out  TAG_BITS  address tag.
out_index  out  INDEX_BITS  address set index.
out_offset  out  OFFSET_BITS  byte select.
clear_req  out  1  cache clear request; held until clear_ack.
clear_ack  in  1  cache clear done.
print_req  out  1  one-cycle pulse requesting a cache dump.
read_count, write_count, ifetch_count, snoop_count, bad_cmd_count  out  CNT_W each  statistics.
busy  out  1  FIFO not empty or FSM not in S_IDLE.

Behaviour:
- Reset:
  - FIFO emptied; FSM goes to S_IDLE.
  - in_ready=1; out_valid=0; clear_req=0; print_req=0; busy=0.
  - All counters 0; out_op/out_tag/out_index/out_offset=0.
  - Reset mid-operation discards buffered entries and any pending clear.
- Enqueue: on in_valid && in_ready, the codes are handled as follows.
  - Codes 0–6, 8, 9 are written to the FIFO.
  - Codes 7 and 10–15 are dropped (never enqueued) and bad_cmd_count increments in the same cycle.
- No write bypass: when full, in_ready=0 even if a dequeue happens that cycle.
- Latency: an entry accepted at edge N is visible at the head by edge N+1 (out_valid high in the cycle after acceptance when the FIFO was empty).
- Decode map:
  - 0→OP_RD, 1→OP_WR, 2→OP_IF.
  - 3→OP_SNP_RD, 4→OP_SNP_WR, 5→OP_SNP_RWIM, 6→OP_SNP_INV.
  - 8→clear, 9→print.
- Address split: tag=addr[ADDR_W-1 -: TAG_BITS], index=next INDEX_BITS, offset=low OFFSET_BITS.
- FSM states:
  - S_IDLE: FIFO empty. Moves to S_ISSUE when the FIFO becomes non-empty.
  - S_ISSUE, head code 0–6:
    - out_valid=1 and outputs are driven from the head, stable until the handshake.
    - On out_ready, pop the entry and increment the class counter: 0→read, 1→write, 2→ifetch, 3–6→snoop.
    - Then stay in S_ISSUE if more entries remain, else go to S_IDLE.
  - S_ISSUE, head code 8: go to S_CLEAR with out_valid=0.
  - S_ISSUE, head code 9: go to S_PRINT with out_valid=0.
  - S_CLEAR: clear_req=1.
    - On clear_ack, pop the entry, zero read/write/ifetch/snoop counters (bad_cmd_count kept), then go to S_ISSUE or S_IDLE.
    - clear_ack outside S_CLEAR is ignored.
  - S_PRINT: print_req=1 for exactly one cycle and the entry is popped; next state is S_ISSUE or S_IDLE.
- Command order is preserved strictly; a clear blocks later operations until acknowledged.
- Counters saturate at all-ones and never wrap.
- Simultaneous enqueue and dequeue when not full: both occur and occupancy is unchanged.

Optional Feature:
TRACE_RX_DEBUG_EN
- Defined: on every enqueue, $display of command number, address in hex, and the tag/index/offset split in binary.
- Also defined: $display of "bad command" for each dropped code.
- Not defined: no display output; RTL behaviour is identical.

Decomposition:
- mypkg holds:
  - op_e enum (3-bit).
  - Command code constants CMD_RD=0 … CMD_SNP_INV=6, CMD_CLEAR=8, CMD_PRINT=9.
  - Existing TAG_BITS/INDEX_BITS/OFFSET_BITS.
  - fsm_e {S_IDLE,S_ISSUE,S_CLEAR,S_PRINT}.
- One sub-module, trace_fifo: parameterised synchronous FIFO (width 4+ADDR_W, FIFO_DEPTH) with full/empty.
- The existing address_parse is reused for the split.

Test Plan:
- Stimulus: cmd 0 addr 0x12345678 with out_ready=1. Response: out_valid one cycle after accept, out_op=OP_RD, split fields match address_parse, read_count=1.
- Stimulus: out_ready=0 while pushing five commands (FIFO_DEPTH=4). Response: in_ready drops after 4 accepts; then raise out_ready and check order 0,1,2,3 followed by the fifth.
- Stimulus: cmd 7 and cmd 15. Response: neither reaches out_valid, bad_cmd_count=2, in_ready stays 1.
- Stimulus: sequence 1, 8, 0 with clear_ack delayed 5 cycles. Response: OP_WR issued; clear_req high 5 cycles; counters zeroed; OP_RD issued only after ack; final write_count=0, read_count=1.
- Stimulus: cmd 9 between two cmd 2. Response: print_req is exactly one cycle wide between the two OP_IF handshakes; ifetch_count=2.
- Stimulus: assert rst with 3 entries buffered and clear_req high. Response: all outputs return to reset values asynchronously and nothing is issued after release.

Source files
------------

// File: rtl/trace_cmd_receiver_pkg.sv
// Shared types, command codes and address split for the trace command receiver.
package trace_cmd_receiver_pkg;

    localparam int TAG_BITS    = 12;
    localparam int INDEX_BITS  = 14;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = TAG_BITS + INDEX_BITS + OFFSET_BITS;

    typedef enum logic [2:0] {
        OP_RD, OP_WR, OP_IF, OP_SNP_RD, OP_SNP_WR, OP_SNP_RWIM, OP_SNP_INV
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CLEAR, S_PRINT} fsm_e;

    localparam logic [3:0] CMD_RD       = 4'd0;
    localparam logic [3:0] CMD_WR       = 4'd1;
    localparam logic [3:0] CMD_IF       = 4'd2;
    localparam logic [3:0] CMD_SNP_RD   = 4'd3;
    localparam logic [3:0] CMD_SNP_WR   = 4'd4;
    localparam logic [3:0] CMD_SNP_RWIM = 4'd5;
    localparam logic [3:0] CMD_SNP_INV  = 4'd6;
    localparam logic [3:0] CMD_CLEAR    = 4'd8;
    localparam logic [3:0] CMD_PRINT    = 4'd9;

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [OFFSET_BITS-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t address_parse(input logic [ADDR_BITS-1:0] addr);
        addr_fields_t f;
        f.tag    = addr[ADDR_BITS-1 -: TAG_BITS];
        f.index  = addr[OFFSET_BITS +: INDEX_BITS];
        f.offset = addr[OFFSET_BITS-1:0];
        return f;
    endfunction

    function automatic logic cmd_is_op(input logic [3:0] cmd);
        return cmd <= CMD_SNP_INV;
    endfunction

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return cmd_is_op(cmd) || (cmd == CMD_CLEAR) || (cmd == CMD_PRINT);
    endfunction

    function automatic op_e decode_op(input logic [3:0] cmd);
        case (cmd)
            CMD_WR:       return OP_WR;
            CMD_IF:       return OP_IF;
            CMD_SNP_RD:   return OP_SNP_RD;
            CMD_SNP_WR:   return OP_SNP_WR;
            CMD_SNP_RWIM: return OP_SNP_RWIM;
            CMD_SNP_INV:  return OP_SNP_INV;
            default:      return OP_RD;
        endcase
    endfunction

endpackage

// File: rtl/trace_cmd_receiver_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module trace_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trace_cmd_receiver.sv
// Trace command receiver: buffers {cmd, addr}, decodes to cache ops, sequences clear/print.
// Optional TRACE_RX_DEBUG_EN prints every accepted and dropped command.
module trace_cmd_receiver
    import trace_cmd_receiver_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_cmd,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_op,
    output logic [TAG_BITS-1:0]    out_tag,
    output logic [INDEX_BITS-1:0]  out_index,
    output logic [OFFSET_BITS-1:0] out_offset,
    output logic                   clear_req,
    input  logic                   clear_ack,
    output logic                   print_req,
    output logic [CNT_W-1:0]       read_count,
    output logic [CNT_W-1:0]       write_count,
    output logic [CNT_W-1:0]       ifetch_count,
    output logic [CNT_W-1:0]       snoop_count,
    output logic [CNT_W-1:0]       bad_cmd_count,
    output logic                   busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_e              state;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W+3:0] head;
    logic [3:0]        head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic              accept;
    logic              is_good;
    logic              push;
    logic              pop;
    logic              more;
    addr_fields_t      fields;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    trace_fifo #(.WIDTH(ADDR_W + 4), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_cmd, in_addr}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign is_good   = cmd_is_valid(in_cmd);
    assign push      = accept && is_good;
    assign head_cmd  = head[ADDR_W+3:ADDR_W];
    assign head_addr = head[ADDR_W-1:0];
    // Entries left after this cycle's pop, counting a same-cycle push.
    assign more      = (fifo_count > CW'(1)) || push;
    assign fields    = address_parse(head_addr);

    assign out_valid  = (state == S_ISSUE) && !fifo_empty && cmd_is_op(head_cmd);
    assign out_op     = out_valid ? decode_op(head_cmd) : OP_RD;
    assign out_tag    = out_valid ? fields.tag    : '0;
    assign out_index  = out_valid ? fields.index  : '0;
    assign out_offset = out_valid ? fields.offset : '0;
    assign clear_req  = (state == S_CLEAR);
    assign print_req  = (state == S_PRINT);
    assign busy       = !fifo_empty || (state != S_IDLE);

    always_comb begin
        pop = 1'b0;
        case (state)
            S_ISSUE: pop = out_valid && out_ready;
            S_CLEAR: pop = clear_ack;
            S_PRINT: pop = 1'b1;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            read_count    <= '0;
            write_count   <= '0;
            ifetch_count  <= '0;
            snoop_count   <= '0;
            bad_cmd_count <= '0;
        end else begin
            if (accept && !is_good) bad_cmd_count <= sat_inc(bad_cmd_count);
            case (state)
                S_IDLE: begin
                    if (push || !fifo_empty) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (fifo_empty) begin
                        state <= push ? S_ISSUE : S_IDLE;
                    end else if (cmd_is_op(head_cmd)) begin
                        if (out_ready) begin
                            case (head_cmd)
                                CMD_RD:  read_count   <= sat_inc(read_count);
                                CMD_WR:  write_count  <= sat_inc(write_count);
                                CMD_IF:  ifetch_count <= sat_inc(ifetch_count);
                                default: snoop_count  <= sat_inc(snoop_count);
                            endcase
                            state <= more ? S_ISSUE : S_IDLE;
                        end
                    end else if (head_cmd == CMD_CLEAR) begin
                        state <= S_CLEAR;
                    end else begin
                        state <= S_PRINT;
                    end
                end
                S_CLEAR: begin
                    if (clear_ack) begin
                        read_count   <= '0;
                        write_count  <= '0;
                        ifetch_count <= '0;
                        snoop_count  <= '0;
                        state        <= more ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    state <= more ? S_ISSUE : S_IDLE;
                end
            endcase
        end
    end

`ifdef TRACE_RX_DEBUG_EN
    addr_fields_t dbg_fields;
    assign dbg_fields = address_parse(in_addr);

    always @(posedge clk) begin
        if (push)
            $display("trace_rx: cmd %0d addr %h tag %b index %b offset %b",
                     in_cmd, in_addr, dbg_fields.tag, dbg_fields.index, dbg_fields.offset);
        if (accept && !is_good)
            $display("trace_rx: bad command %0d", in_cmd);
    end
`else
    // Quiet build: no trace output.
`endif

endmodule

// File: tb/tb_trace_cmd_receiver.sv
// Directed table-driven bench for trace_cmd_receiver, built with 4-bit counters to reach saturation.
module tb_trace_cmd_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [11:0] out_tag;
    logic [13:0] out_index;
    logic [5:0]  out_offset;
    logic        clear_req;
    logic        clear_ack;
    logic        print_req;
    logic [3:0]  read_count, write_count, ifetch_count, snoop_count, bad_cmd_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    trace_cmd_receiver #(.ADDR_W(32), .FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
        .clear_req(clear_req), .clear_ack(clear_ack), .print_req(print_req),
        .read_count(read_count), .write_count(write_count), .ifetch_count(ifetch_count),
        .snoop_count(snoop_count), .bad_cmd_count(bad_cmd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        vld;
        logic [2:0]  op;
        logic [11:0] tag;
        logic [13:0] idx;
        logic [5:0]  off;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  got, clr_cyc, ifs, pr_cyc, ifs_at_pr;
    logic acc, seen_wr, seen_rd, acked, rd_after_ack, leaked;
    logic [2:0] exp_order [5];

    initial begin
        vec[0] = '{4'd0,  32'h12345678, 1'b1, 3'd0, 12'h123, 14'h1159, 6'h38};
        vec[1] = '{4'd1,  32'hFFFFFFFF, 1'b1, 3'd1, 12'hFFF, 14'h3FFF, 6'h3F};
        vec[2] = '{4'd2,  32'h00000000, 1'b1, 3'd2, 12'h000, 14'h0000, 6'h00};
        vec[3] = '{4'd3,  32'h80000001, 1'b1, 3'd3, 12'h800, 14'h0000, 6'h01};
        vec[4] = '{4'd4,  32'h000FFFC0, 1'b1, 3'd4, 12'h000, 14'h3FFF, 6'h00};
        vec[5] = '{4'd5,  32'hABCDE03F, 1'b1, 3'd5, 12'hABC, 14'h3780, 6'h3F};
        vec[6] = '{4'd6,  32'h00100040, 1'b1, 3'd6, 12'h001, 14'h0001, 6'h00};
        vec[7] = '{4'd7,  32'hDEADBEEF, 1'b0, 3'd0, 12'h000, 14'h0000, 6'h00};
        vec[8] = '{4'd15, 32'hCAFEF00D, 1'b0, 3'd0, 12'h000, 14'h0000, 6'h00};
        exp_order[0] = 3'd0; exp_order[1] = 3'd1; exp_order[2] = 3'd2;
        exp_order[3] = 3'd3; exp_order[4] = 3'd4;

        rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0;
        out_ready = 1'b1; clear_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_clear_req", clear_req, 0);
        chk("rst_print_req", print_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_fields", {out_op, out_tag, out_index, out_offset}, 0);
        chk("rst_counts", {read_count, write_count, ifetch_count, snoop_count, bad_cmd_count}, 0);
        rst = 1'b0;
        step();

        // Single commands through an idle receiver.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_cmd = vec[i].cmd; in_addr = vec[i].addr;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, vec[i].vld);
            if (vec[i].vld) begin
                chk($sformatf("v%0d_op", i), out_op, vec[i].op);
                chk($sformatf("v%0d_tag", i), out_tag, vec[i].tag);
                chk($sformatf("v%0d_index", i), out_index, vec[i].idx);
                chk($sformatf("v%0d_offset", i), out_offset, vec[i].off);
                step();
                chk($sformatf("v%0d_popped", i), out_valid, 0);
            end
            chk($sformatf("v%0d_busy", i), busy, 0);
        end
        chk("tbl_read", read_count, 1);
        chk("tbl_write", write_count, 1);
        chk("tbl_ifetch", ifetch_count, 1);
        chk("tbl_snoop", snoop_count, 4);
        chk("tbl_bad", bad_cmd_count, 2);

        // Fill the FIFO with out_ready low; fifth command must wait.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cmd = 4'(i); in_addr = 32'h1000 * i;
            chk($sformatf("fill%0d_in_ready", i), in_ready, (i < 4) ? 1 : 0);
            if (i < 4) step();
        end
        out_ready = 1'b1;
        chk("no_bypass", in_ready, 0);
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (out_valid) begin
                chk($sformatf("order%0d", got), out_op, exp_order[got]);
                got++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("order_count", got, 5);
        chk("fill_read", read_count, 2);
        chk("fill_snoop", snoop_count, 6);

        // Stray clear_ack while idle is ignored.
        clear_ack = 1'b1; step(); clear_ack = 1'b0;
        chk("stray_ack_write", write_count, 2);
        chk("stray_ack_busy", busy, 0);

        // Sequence WR, CLEAR, RD with a five-cycle acknowledge.
        out_ready = 1'b0;
        in_valid = 1'b1; in_cmd = 4'd1; in_addr = 32'h40; step();
        in_cmd = 4'd8; step();
        in_cmd = 4'd0; step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_cyc = 0; seen_wr = 0; seen_rd = 0; acked = 0; rd_after_ack = 0;
        for (int c = 0; c < 60 && !seen_rd; c++) begin
            clear_ack = 1'b0;
            if (out_valid && out_op == 3'd1) seen_wr = 1'b1;
            if (out_valid && out_op == 3'd0) begin seen_rd = 1'b1; rd_after_ack = acked; end
            if (clear_req) begin
                clr_cyc++;
                if (clr_cyc == 5) begin clear_ack = 1'b1; acked = 1'b1; end
            end
            step();
        end
        clear_ack = 1'b0;
        chk("clr_wr_issued", seen_wr, 1);
        chk("clr_req_cycles", clr_cyc, 5);
        chk("clr_rd_after_ack", {seen_rd, rd_after_ack}, 2'b11);
        chk("clr_write", write_count, 0);
        chk("clr_read", read_count, 1);
        chk("clr_snoop", snoop_count, 0);
        chk("clr_bad_kept", bad_cmd_count, 2);

        // IF, PRINT, IF: one-cycle print pulse between the two fetches.
        out_ready = 1'b0;
        in_valid = 1'b1; in_cmd = 4'd2; in_addr = 32'h80; step();
        in_cmd = 4'd9; step();
        in_cmd = 4'd2; step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        ifs = 0; pr_cyc = 0; ifs_at_pr = -1;
        for (int c = 0; c < 30 && ifs < 2; c++) begin
            if (print_req) begin pr_cyc++; ifs_at_pr = ifs; end
            if (out_valid && out_op == 3'd2) ifs++;
            step();
        end
        chk("prt_ifs", ifs, 2);
        chk("prt_width", pr_cyc, 1);
        chk("prt_between", ifs_at_pr, 1);
        chk("prt_ifetch", ifetch_count, 2);
        chk("prt_busy", busy, 0);

        // Asynchronous reset with three entries buffered and clear pending.
        out_ready = 1'b0;
        in_valid = 1'b1; in_cmd = 4'd8; step();
        in_cmd = 4'd0; step();
        in_cmd = 4'd1; step();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !clear_req; c++) step();
        chk("pre_rst_clear_req", clear_req, 1);
        rst = 1'b1;
        #2;
        chk("arst_clear_req", clear_req, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_counts", {read_count, write_count, ifetch_count, snoop_count, bad_cmd_count}, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1; clear_ack = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid || clear_req || busy) leaked = 1'b1;
            step();
        end
        clear_ack = 1'b0;
        chk("post_rst_quiet", leaked, 0);

        // Bad-command counter saturates at all ones.
        in_valid = 1'b1; in_cmd = 4'd10;
        for (int i = 0; i < 17; i++) step();
        in_valid = 1'b0;
        chk("sat_bad", bad_cmd_count, 4'hF);
        chk("sat_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
